// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 8N1 serial receiver with 16x oversampling and 3-sample voting.
//
// Recovers LSB-first frames from the asynchronous rx line, presents each good
// byte on rx_data with a one-cycle rx_valid strobe, and pulses frame_err when
// the stop bit is sampled low. After a framing error the receiver waits for
// the line to return high before it will look for a new start edge.
//
// Parameters:
//   DATA_BITS  data bits per frame (default 8)
//   OS_RATE    os_en ticks per bit period, even and >= 8 (default 16)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   os_en      one-clk pulse at OS_RATE x baud
//   rx_data    last correctly received byte
//   rx_valid   one-cycle pulse when rx_data is updated
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   busy       high while a frame (or the post-error break wait) is active
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 os_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int M  = OS_RATE / 2;
    localparam int SW = $clog2(OS_RATE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] S_M_MINUS = SW'(M - 1);
    localparam logic [SW-1:0] S_M       = SW'(M);
    localparam logic [SW-1:0] S_M_PLUS  = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OS_RATE - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t                 state_q,     state_d;
    logic                   rx_meta_q,   rx_meta_d;
    logic                   rx_s_q,      rx_s_d;
    logic [SW-1:0]          s_cnt_q,     s_cnt_d;
    logic [BW-1:0]          b_cnt_q,     b_cnt_d;
    logic                   smp_lo_q,    smp_lo_d;   // sample at s_cnt = M-1
    logic                   smp_mid_q,   smp_mid_d;  // sample at s_cnt = M
    logic                   bit_q,       bit_d;      // voted data bit, held to end of bit
    logic [DATA_BITS-1:0]   shreg_q,     shreg_d;
    logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   vote;

    // The third vote is the live synchronized sample, so the majority is valid
    // exactly on the os_en tick where s_cnt = M+1.
    assign vote = majority3(smp_lo_q, smp_mid_q, rx_s_q);

    always_comb begin
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        s_cnt_d     = s_cnt_q;
        b_cnt_d     = b_cnt_q;
        smp_lo_d    = smp_lo_q;
        smp_mid_d   = smp_mid_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        if (os_en && (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP)) begin
            if (s_cnt_q == S_M_MINUS) smp_lo_d  = rx_s_q;
            if (s_cnt_q == S_M)       smp_mid_d = rx_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                // Edge detection is clk-driven; an os_en on this cycle is ignored.
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                    b_cnt_d = '0;
                end
            end

            ST_START: begin
                if (os_en) begin
                    if (s_cnt_q == S_M_PLUS && vote) begin
                        // Glitch, not a start bit.
                        state_d = ST_IDLE;
                        s_cnt_d = '0;
                    end else if (s_cnt_q == S_LAST) begin
                        state_d = ST_DATA;
                        s_cnt_d = '0;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (os_en) begin
                    if (s_cnt_q == S_M_PLUS) bit_d = vote;
                    if (s_cnt_q == S_LAST) begin
                        // Shift right into the MSB so the first (LSB) bit ends at bit 0.
                        shreg_d = {bit_q, shreg_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        if (b_cnt_q == B_LAST) begin
                            b_cnt_d = '0;
                            state_d = ST_STOP;
                        end else begin
                            b_cnt_d = b_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                // Decide at mid-bit and leave immediately so a back-to-back start
                // edge at the end of the stop bit is seen from IDLE.
                if (os_en) begin
                    if (s_cnt_q == S_M_PLUS) begin
                        s_cnt_d = '0;
                        if (vote) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            ST_BREAK: begin
                // Never restart on a low level; wait for the line to go idle.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                    s_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                s_cnt_d = '0;
                b_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            s_cnt_q     <= '0;
            b_cnt_q     <= '0;
            smp_lo_q    <= 1'b1;
            smp_mid_q   <= 1'b1;
            bit_q       <= 1'b0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            s_cnt_q     <= s_cnt_d;
            b_cnt_q     <= b_cnt_d;
            smp_lo_q    <= smp_lo_d;
            smp_mid_q   <= smp_mid_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    // Derived from the state register, so it drops in the same cycle rx_valid rises.
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx.
//
// A table of frames (data, stop level, post-frame low hold, noise position,
// idle gap, expected strobes and rx_data) is applied in a loop; hand-written
// sequences cover reset values, a false start and a mid-frame reset. A free
// running monitor counts strobes, captures received bytes and checks strobe
// exclusivity, width and busy at rx_valid. os_en is generated every OS_DIV
// clocks to keep frames short.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DATA_BITS = 8;
    localparam int OS_RATE   = 16;
    localparam int OS_DIV    = 4;
    localparam int M         = OS_RATE / 2;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 rx    = 1'b1;
    logic                 os_en = 1'b0;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_ferr   = 0;
    logic [7:0] rxq[$];

    uart_rx #(
        .DATA_BITS(DATA_BITS),
        .OS_RATE  (OS_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .os_en    (os_en),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div   = (div == OS_DIV - 1) ? 0 : div + 1;
            os_en = (div == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    initial begin
        logic prev_valid;
        logic prev_ferr;
        prev_valid = 1'b0;
        prev_ferr  = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid || frame_err) begin
                check("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
                check("strobe_width", {31'd0, (rx_valid & prev_valid) | (frame_err & prev_ferr)}, 32'd0);
            end
            if (rx_valid) begin
                check("busy_low_at_valid", {31'd0, busy}, 32'd0);
                rxq.push_back(rx_data);
                n_valid++;
            end
            if (frame_err) n_ferr++;
            prev_valid = rx_valid;
            prev_ferr  = frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns 1 time unit after the n-th os_en edge, so rx changes off-edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!os_en) @(posedge clk);
        end
        #1;
    endtask

    // noise >= 0 inverts rx for one os_en period around the s_cnt = M sample
    // of that data bit.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int hold, input int noise);
        rx = 1'b0;
        wait_ticks(OS_RATE);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = data[i];
            if (i == noise) begin
                wait_ticks(M);
                rx = ~data[i];
                wait_ticks(1);
                rx = data[i];
                wait_ticks(OS_RATE - M - 1);
            end else begin
                wait_ticks(OS_RATE);
            end
        end
        rx = stop;
        wait_ticks(OS_RATE * (1 + hold));
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         hold;
        int         noise;
        int         gap;
        logic       exp_valid;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        int v_before;
        int f_before;

        vecs[0] = '{8'hA5, 1'b1, 0, -1, 2, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 3, -1, 2, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{8'h81, 1'b1, 0, -1, 2, 1'b1, 1'b0, 8'h81};
        vecs[3] = '{8'h00, 1'b1, 0, -1, 0, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0, -1, 0, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'h55, 1'b1, 0, -1, 2, 1'b1, 1'b0, 8'h55};
        vecs[6] = '{8'hF0, 1'b1, 0,  3, 2, 1'b1, 1'b0, 8'hF0};
        vecs[7] = '{8'h01, 1'b1, 0, -1, 2, 1'b1, 1'b0, 8'h01};
        vecs[8] = '{8'h80, 1'b1, 0, -1, 2, 1'b1, 1'b0, 8'h80};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data",   {24'd0, rx_data},   32'h00);
        check("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_ticks(4);

        // False start: low for 4 ticks only
        rx = 1'b0;
        wait_ticks(1);
        check("busy_rise", {31'd0, busy}, 32'd1);
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(M + 4);
        check("false_start_busy", {31'd0, busy}, 32'd0);
        wait_ticks(2 * OS_RATE);
        check("false_start_valid", n_valid, 0);
        check("false_start_ferr",  n_ferr,  0);
        check("false_start_data",  {24'd0, rx_data}, 32'h00);

        // Table-driven frames
        for (int i = 0; i < NV; i++) begin
            v_before = n_valid;
            f_before = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold, vecs[i].noise);
            wait_ticks(OS_RATE * vecs[i].gap);
            check($sformatf("vec%0d_valid_cnt", i), n_valid - v_before, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_ferr_cnt", i),  n_ferr - f_before,  {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d_rx_data", i),   {24'd0, rx_data},   {24'd0, vecs[i].exp_data});
            if (vecs[i].exp_valid && rxq.size() > 0)
                check($sformatf("vec%0d_strobe_data", i), {24'd0, rxq[$]}, {24'd0, vecs[i].exp_data});
            if (vecs[i].gap > 0)
                check($sformatf("vec%0d_busy_idle", i), {31'd0, busy}, 32'd0);
        end
        check("total_valid", n_valid, 8);
        check("total_ferr",  n_ferr,  1);
        check("b2b_order", {8'd0, rxq[2], rxq[3], rxq[4]}, 32'h0000FF55);

        // Reset during data bit 4 of 0x1F
        v_before = n_valid;
        f_before = n_ferr;
        rx = 1'b0;
        wait_ticks(OS_RATE);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_ticks(OS_RATE);
        end
        rx = 1'b1;
        wait_ticks(M);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rx_data",   {24'd0, rx_data},   32'h00);
        check("midrst_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        check("midrst_busy",      {31'd0, busy},      32'd0);
        wait_ticks(3 * OS_RATE);
        check("midrst_no_valid", n_valid - v_before, 0);
        check("midrst_no_ferr",  n_ferr - f_before,  0);
        send_frame(8'h5A, 1'b1, 0, -1);
        wait_ticks(2 * OS_RATE);
        check("after_rst_valid", n_valid - v_before, 1);
        check("after_rst_data",  {24'd0, rx_data}, 32'h5A);
        check("after_rst_busy",  {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, the receive-side counterpart of `uart_tx` on the 9600-baud 8N1 link.
- Samples the `rx` line using a 16× oversampling tick from a `baud_generator` instance configured for 153 600 Hz.
- Recovers 8N1 frames, LSB first, and presents each byte on a parallel bus with a one-cycle valid strobe.
- Flags framing errors.
- Sits between the board's `RsRx` pin and the byte consumer (LEDs/FIFO) in the top level.

## Interface
- `DATA_BITS`, default 8: data bits per frame.
- `OS_RATE`, default 16: `os_en` ticks per bit period; must be even and ≥ 8.
- `clk` input, 1 bit: system clock, 100 MHz.
- `rst` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `rx` input, 1 bit: asynchronous serial line, idle high.
- `os_en` input, 1 bit: one-`clk`-cycle pulse at `OS_RATE` × baud.
- `rx_data` output, `DATA_BITS` bits: last correctly received byte.
- `rx_valid` output, 1 bit: one-cycle pulse when `rx_data` is updated.
- `frame_err` output, 1 bit: one-cycle pulse when a stop bit is sampled low.
- `busy` output, 1 bit: high while a frame is in progress, including the break wait.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- **Counters:**
  - `s_cnt` (0..OS_RATE-1) advances only on `os_en`.
  - `b_cnt` (0..DATA_BITS-1) counts data bits.
  - `s_cnt` clears on every state change.
- **Voting:** within each bit period, `rx_s` is captured on the `os_en` pulses where `s_cnt` = M-1, M and M+1, with M = OS_RATE/2. The bit value is the majority of these 3 samples.
- **States:**
  - **IDLE:** `busy`=0. When `rx_s`=0, go to START on the next `clk`, independent of `os_en`.
  - **START:**
    - Majority evaluated on the `os_en` where `s_cnt`=M+1.
    - Majority 1 means a false start: go to IDLE, no outputs.
    - Otherwise continue to `s_cnt`=OS_RATE-1 with `os_en`, then go to DATA.
  - **DATA:**
    - At `s_cnt`=OS_RATE-1 with `os_en`, shift the majority bit into the MSB of a shift register (shift right, so LSB-first order is restored).
    - Increment `b_cnt`.
    - After DATA_BITS bits, go to STOP.
  - **STOP:** majority evaluated at `s_cnt`=M+1 with `os_en`; the state does not wait out the full bit, so the receiver resyncs on back-to-back frames.
    - Majority 1: `rx_data` ← shift register, pulse `rx_valid`, go to IDLE.
    - Majority 0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - **BREAK:** wait until `rx_s`=1, then go to IDLE. Covers a line held low or a break condition, so the receiver never starts on a low level.
- **No flow control:** the consumer must capture `rx_data` on `rx_valid`. `rx_data` holds until the next valid frame, so there is no overrun detection.
- **`os_en` gaps:** `os_en` absent means the FSM holds, except for the IDLE→START and BREAK→IDLE exits, which are `clk`-driven.

## Timing
- **Reset values:** state IDLE, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, counters 0, synchronizer flops 1.
- **Reset mid-frame:** aborts the frame with no `rx_valid` or `frame_err`. The next falling edge after reset is received normally.
- **Input latency:** 2 `clk` cycles from `rx` pin to `rx_s`.
- **`busy` assertion:** `busy` rises the `clk` after `rx_s` falls in IDLE.
- **Strobe timing:**
  - `rx_valid` and `frame_err` are registered. Each is high for exactly 1 `clk`, in the cycle after the deciding `os_en` pulse.
  - They are never high together.
  - `busy` falls in the same cycle as `rx_valid`.
- **End-of-frame latency:** the frame completes (M+2) `os_en` ticks into the stop bit, about 9.56 bit periods (≈996 µs at 9600 baud) after the start edge.
- **Sampling jitter:** start-edge detection uncertainty is ≤1 `os_en` period plus 3 `clk`. The sample point lands within ±1/16 bit of centre.
- **Back-to-back frames:** a start edge arriving while in STOP after the decision point is caught in IDLE on the following cycle. No idle gap is required between frames.
- **`os_en` on the IDLE→START cycle:** ignored; counting starts with the next pulse.

## Test plan
- **Single frame:** drive 0xA5 8N1 at 9600 baud with `os_en` every 651 clk → `rx_valid` pulse once, `rx_data`=0xA5, `frame_err`=0, `busy` 1 for ≈9.56 bit periods.
- **False start:** `rx` low for 4 `os_en` ticks, then high → returns to IDLE by tick M+1, no `rx_valid`/`frame_err`, `busy` back to 0, `rx_data` unchanged.
- **Framing error and recovery:**
  - Send 0x3C with stop bit 0 → one `frame_err` pulse, no `rx_valid`, `rx_data` keeps its prior value.
  - Hold `rx` low 3 more bit periods, then idle, then send 0x81 → `rx_valid` with `rx_data`=0x81.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with no idle gap → three `rx_valid` pulses with data 0x00, 0xFF, 0x55 in order, no `frame_err`.
- **Noise tolerance:** invert `rx` for exactly the `s_cnt`=M sample of bit 3 in frame 0xF0 → `rx_data`=0xF0 (majority vote).
- **Reset mid-frame:** assert `rst` for 1 clk during bit 4 of a frame → all outputs 0 next cycle, no strobe. A following 0x5A frame is received correctly.
